// File: rtl/alu_seq_ctrl.sv
// Byte-serial ALU sequencer: collects A, B and OP from one stream,
// waits one cycle for the ALU, then holds the result until taken.
module alu_seq_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_en_A,
    output logic               o_en_B,
    output logic               o_en_OP,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_zero,
    input  logic               i_alu_overflow,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_overflow,
    output logic               o_timeout,
    output logic               o_busy
);

    if (NB_OP > NB_DATA) begin : g_nb_op_check
        $error("NB_OP must not exceed NB_DATA");
    end

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 tmo_q, tmo_d;
    logic [NB_DATA-1:0]   res_q, res_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;

    logic accept;
    logic idle;
    logic expire;

    // Handshake and load enables are purely combinational; the
    // enables are forced low while reset is asserted.
    assign o_ready = (state_q == WAIT_A) || (state_q == WAIT_B) ||
                     (state_q == WAIT_OP);
    assign accept  = i_valid && o_ready && i_rst;
    assign o_data  = i_data;
    assign o_en_A  = accept && (state_q == WAIT_A);
    assign o_en_B  = accept && (state_q == WAIT_B);
    assign o_en_OP = accept && (state_q == WAIT_OP);
    assign o_busy  = (state_q != WAIT_A);

    assign idle    = ((state_q == WAIT_B) || (state_q == WAIT_OP)) &&
                     !accept;
    assign expire  = (TIMEOUT != 0) && idle && (cnt_q == CNT_LAST);

    assign o_valid    = valid_q;
    assign o_result   = res_q;
    assign o_zero     = zero_q;
    assign o_overflow = ovf_q;
    assign o_timeout  = tmo_q;

    // Next-state, idle counter and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        if (!idle || expire) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            WAIT_A: begin
                if (accept) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (accept) begin
                    state_d = WAIT_OP;
                end else if (expire) begin
                    state_d = WAIT_A;
                    tmo_d   = 1'b1;
                end
            end
            WAIT_OP: begin
                if (accept) begin
                    state_d = EXEC;
                end else if (expire) begin
                    state_d = WAIT_A;
                    tmo_d   = 1'b1;
                end
            end
            EXEC: begin
                state_d = RESP;
                valid_d = 1'b1;
                res_d   = i_alu_result;
                zero_d  = i_alu_zero;
                ovf_d   = i_alu_overflow;
            end
            RESP: begin
                if (i_ready) begin
                    state_d = WAIT_A;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= WAIT_A;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: vector table plus hand-built corner cases,
// results checked against a queue of expected values.
module tb_alu_seq_ctrl;

    localparam int NBD = 8;
    localparam int TO  = 4;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       v;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] er;
        logic       ez;
        logic       ev;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_valid;
    logic [NBD-1:0] i_data;
    logic           o_ready;
    logic [NBD-1:0] o_data;
    logic           en_a, en_b, en_op;
    logic [NBD-1:0] alu_res;
    logic           alu_z, alu_v;
    logic           o_valid;
    logic           i_ready;
    logic [NBD-1:0] o_result;
    logic           o_zero, o_ovf, o_tmo, o_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int op_cyc = -100;
    logic prev_v = 1'b0;
    res_t sb[$];

    logic [7:0] a_q = '0, b_q = '0, op_q = '0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NB_DATA(NBD), .NB_OP(6), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_data(o_data),
        .o_en_A(en_a), .o_en_B(en_b), .o_en_OP(en_op),
        .i_alu_result(alu_res),
        .i_alu_zero(alu_z), .i_alu_overflow(alu_v),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_zero(o_zero),
        .o_overflow(o_ovf), .o_timeout(o_tmo),
        .o_busy(o_busy)
    );

    // Behavioural ALU fed by the registers the DUT loads.
    function automatic res_t alu(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic [7:0] op);
        res_t o;
        o = '0;
        case (op)
            8'h20: begin
                o.r = a + b;
                o.v = (a[7] == b[7]) && (o.r[7] != a[7]);
            end
            8'h22: begin
                o.r = a - b;
                o.v = (a[7] != b[7]) && (o.r[7] != a[7]);
            end
            8'h24: o.r = a & b;
            8'h25: o.r = a | b;
            default: o.r = a ^ b;
        endcase
        o.z = (o.r == 8'h00);
        return o;
    endfunction

    always @(posedge clk) begin
        if (en_a)  a_q  <= o_data;
        if (en_b)  b_q  <= o_data;
        if (en_op) op_q <= o_data;
    end

    res_t alu_o;
    assign alu_o   = alu(a_q, b_q, op_q);
    assign alu_res = alu_o.r;
    assign alu_z   = alu_o.z;
    assign alu_v   = alu_o.v;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    // Per-cycle monitor: enable exclusivity, result scoreboard, latency.
    always @(negedge clk) begin
        res_t e;
        cyc++;
        chk("en_onehot", 32'($countones({en_a, en_b, en_op}) <= 1), 1);
        if (en_op) op_cyc = cyc;
        if (o_valid && !prev_v) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(o_result), 32'(e.r));
                chk("zero", 32'(o_zero), 32'(e.z));
                chk("ovf", 32'(o_ovf), 32'(e.v));
                chk("latency", 32'(cyc - op_cyc), 2);
            end
        end
        prev_v = o_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int which);
        i_valid = 1'b1;
        i_data  = d;
        #1;
        chk("ready_for_byte", 32'(o_ready), 1);
        chk("o_data_pass", 32'(o_data), 32'(d));
        chk("en_A", 32'(en_a), 32'(which == 0));
        chk("en_B", 32'(en_b), 32'(which == 1));
        chk("en_OP", 32'(en_op), 32'(which == 2));
        tick();
        i_valid = 1'b0;
    endtask

    task automatic send_txn(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] er,
                            input logic ez, input logic ev);
        sb.push_back('{r: er, z: ez, v: ev});
        send_byte(a, 0);
        send_byte(b, 1);
        send_byte(op, 2);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !o_valid; i++) tick();
        chk("valid_seen", 32'(o_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [7:0] strm[6];
        int idx, stalls;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'h7f, 8'h01, 8'h20, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 8'h22, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h22, 8'h7f, 1'b0, 1'b1};
        vecs[4] = '{8'hf0, 8'h3c, 8'h24, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{8'h0f, 8'hf0, 8'h25, 8'hff, 1'b0, 1'b0};
        vecs[6] = '{8'haa, 8'haa, 8'h2f, 8'h00, 1'b1, 1'b0};

        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'haa;
        i_ready = 1'b1;
        tick();
        tick();
        chk("rst_en_A", 32'(en_a), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_tmo", 32'(o_tmo), 0);
        chk("rst_result", 32'(o_result), 0);
        chk("rst_flags", 32'({o_zero, o_ovf}), 0);
        i_valid = 1'b0;
        rst_n   = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            send_txn(vecs[i].a, vecs[i].b, vecs[i].op,
                     vecs[i].er, vecs[i].ez, vecs[i].ev);
            wait_valid();
            tick();
            chk("tbl_back_idle", 32'({o_valid, o_busy}), 0);
        end

        i_ready = 1'b0;
        send_txn(8'h05, 8'h05, 8'h22, 8'h00, 1'b1, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 32'({o_valid, o_result, o_zero, o_ready}),
                32'({1'b1, 8'h00, 1'b1, 1'b0}));
            tick();
        end
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h55;
        #1;
        chk("bp_release_ignored", 32'({o_ready, en_a}), 0);
        tick();
        i_valid = 1'b0;
        chk("bp_after", 32'({o_valid, o_busy, o_ready}), 32'(3'b001));
        chk("bp_hold_res", 32'({o_result, o_zero}), 32'({8'h00, 1'b1}));

        send_byte(8'h33, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tmo_early", 32'({o_tmo, o_busy}), 32'(2'b01));
        end
        tick();
        chk("tmo_pulse", 32'({o_tmo, o_busy}), 32'(2'b10));
        tick();
        chk("tmo_one_cycle", 32'(o_tmo), 0);
        send_txn(8'h11, 8'h22, 8'h25, 8'h33, 1'b0, 1'b0);
        wait_valid();
        tick();

        sb.push_back('{r: 8'h42, z: 1'b0, v: 1'b0});
        send_byte(8'h40, 0);
        for (int i = 0; i < 3; i++) tick();
        send_byte(8'h02, 1);
        chk("exp_no_tmo_b", 32'(o_tmo), 0);
        for (int i = 0; i < 3; i++) tick();
        send_byte(8'h20, 2);
        chk("exp_no_tmo_op", 32'(o_tmo), 0);
        wait_valid();
        tick();

        i_ready = 1'b0;
        send_txn(8'h09, 8'h01, 8'h20, 8'h0a, 1'b0, 1'b0);
        wait_valid();
        rst_n = 1'b0;
        tick();
        chk("rresp_out", 32'({o_valid, o_result, o_ready, o_tmo}),
            32'({1'b0, 8'h00, 1'b1, 1'b0}));
        rst_n   = 1'b1;
        i_ready = 1'b1;
        tick();
        chk("rresp_no_tmo", 32'({o_tmo, o_busy}), 0);

        strm[0] = 8'h01; strm[1] = 8'h02; strm[2] = 8'h20;
        strm[3] = 8'h08; strm[4] = 8'h03; strm[5] = 8'h22;
        sb.push_back('{r: 8'h03, z: 1'b0, v: 1'b0});
        sb.push_back('{r: 8'h05, z: 1'b0, v: 1'b0});
        idx    = 0;
        stalls = 0;
        i_valid = 1'b1;
        for (int g = 0; g < 40 && idx < 6; g++) begin
            i_data = strm[idx];
            #1;
            if (o_ready) begin
                idx++;
            end else begin
                stalls++;
                chk("stream_stall_valid", 32'(o_valid),
                    32'(stalls == 2));
                chk("stream_stall_en", 32'({en_a, en_b, en_op}), 0);
            end
            tick();
        end
        i_valid = 1'b0;
        chk("stream_bytes", 32'(idx), 6);
        chk("stream_stalls", 32'(stalls), 2);
        wait_valid();
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result width in bits.
REQ-002 Parameter NB_OP, default 6, opcode width; SHALL be at most NB_DATA.
REQ-003 Parameter TIMEOUT, default 255, maximum idle cycles between operand bytes; 0 disables the timeout.
REQ-004 i_clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 i_valid  in  1  upstream byte valid.
REQ-007 i_data  in  NB_DATA  upstream byte (A, then B, then OP).
REQ-008 o_ready  out  1  controller can accept a byte.
REQ-009 o_data  out  NB_DATA  byte forwarded to the operand/opcode registers; SHALL equal i_data combinationally.
REQ-010 o_en_A, o_en_B, o_en_OP  out  1 each  register load enables.
REQ-011 i_alu_result  in  NB_DATA  ALU result.
REQ-012 i_alu_zero, i_alu_overflow  in  1 each  ALU flags.
REQ-013 o_valid  out  1  captured result valid.
REQ-014 i_ready  in  1  downstream accepts the result.
REQ-015 o_result  out  NB_DATA  captured result; o_zero and o_overflow  out  1 each  captured flags.
REQ-016 o_timeout  out  1  one-cycle pulse on an aborted transaction.
REQ-017 o_busy  out  1  high in every state except WAIT_A.

Function
REQ-018 FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC and RESP.
REQ-019 Accept SHALL be i_valid AND o_ready; o_ready SHALL be high only in WAIT_A, WAIT_B and WAIT_OP.
REQ-020 o_en_A, o_en_B and o_en_OP SHALL be combinational: each is accept AND (state = WAIT_A, WAIT_B or WAIT_OP respectively); at most one SHALL be high per cycle.
REQ-021 Transitions:
- WAIT_A -> WAIT_B on accept.
- WAIT_B -> WAIT_OP on accept.
- WAIT_OP -> EXEC on accept.
- EXEC -> RESP unconditionally after 1 cycle.
- RESP -> WAIT_A when i_ready is high.
REQ-022 In EXEC, i_alu_result and both ALU flags SHALL be captured into o_result, o_zero and o_overflow at the closing edge; o_valid SHALL rise the same edge.
REQ-023 Latency: OP accepted at edge N; o_valid high from edge N+2.
REQ-024 In RESP, o_valid and the outputs SHALL hold stable until i_ready; backpressure SHALL be unbounded with no timeout.
REQ-025 On the RESP->WAIT_A edge o_valid SHALL clear; o_result and the flags SHALL hold their last values; i_valid in that cycle SHALL be ignored (o_ready is low).
REQ-026 Idle counter behaviour:
- increments each cycle in WAIT_B or WAIT_OP without an accept;
- clears on any accept and in all other states;
- saturating, minimum width to hold TIMEOUT.
REQ-027 When TIMEOUT is non-zero and the counter equals TIMEOUT-1 in a cycle without an accept:
- the next state SHALL be WAIT_A;
- o_timeout SHALL be registered high for exactly one cycle;
- the counter SHALL clear.
REQ-028 When an accept and timeout expiry fall in the same cycle, the accept SHALL win.
REQ-029 An aborted transaction SHALL NOT assert o_valid; register contents already loaded are not cleared.

Reset
REQ-030 While i_rst is low at a clock edge:
- state SHALL become WAIT_A and the counter 0;
- o_valid, o_timeout, o_result, o_zero and o_overflow SHALL become 0.
REQ-031 While i_rst is low, o_en_A, o_en_B and o_en_OP SHALL be 0 regardless of i_valid.
REQ-032 Reset mid-transaction, including in RESP, SHALL discard the transaction without a timeout pulse.

Verification
REQ-033 Basic: reset, then bytes 0x05, 0x03, 0x20 on consecutive cycles, bench ALU drives 0x08, zero=0, ovf=0, i_ready=1 -> one cycle each of en_A, en_B, en_OP; o_valid one cycle at N+2; o_result=0x08.
REQ-034 Backpressure: i_ready low for 10 cycles with ALU 0x00, zero=1 -> o_valid, o_result=0x00 and o_zero=1 stable for all 10 cycles; WAIT_A entered one cycle after i_ready rises.
REQ-035 Timeout: TIMEOUT=4, A accepted, then i_valid low -> o_timeout pulses once 4 cycles later; next byte 0x11 loads A (o_en_A), not B.
REQ-036 Accept at expiry: TIMEOUT=4, B byte presented exactly in the 4th idle cycle -> accepted as B, no o_timeout.
REQ-037 Reset in RESP: i_rst low for 1 cycle with o_valid high -> o_valid=0, o_result=0 and o_ready=1 on the next cycle.
REQ-038 Stream: i_valid held high with 6 bytes -> two results, each with 2-cycle latency after its OP byte, and o_ready low during EXEC and RESP.
